// File: rtl/sys_clk_reset_pkg.sv
// Shared definitions for the system clock reset sequencer: state encoding and status widths.
package sys_clk_reset_pkg;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned LOSS_CNT_W = 8;

  localparam logic [STATE_W-1:0] ST_PLL_RST   = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [STATE_W-1:0] ST_HOLD      = 2'd2;
  localparam logic [STATE_W-1:0] ST_RUN       = 2'd3;

  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  typedef enum logic [STATE_W-1:0] {
    S_PLL_RST   = ST_PLL_RST,
    S_WAIT_LOCK = ST_WAIT_LOCK,
    S_HOLD      = ST_HOLD,
    S_RUN       = ST_RUN
  } seq_state_e;

endpackage

// File: rtl/sys_clk_bit_sync.sv
// Two-flop synchroniser for asynchronous status inputs; resets to 0.
module sys_clk_bit_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sys_clk_reset_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock, then releases the system
// reset after the SDRAM power-up delay. Re-sequences on lock loss or lock timeout.
module sys_clk_reset_sequencer
  import sys_clk_reset_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RELEASE_DELAY       = 5000,
  parameter int unsigned LOCK_GLITCH_CYCLES  = 4,
  parameter int unsigned CNT_W               = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic                  pll_rst,
  output logic                  sys_reset_n,
  output logic                  ready,
  output logic [STATE_W-1:0]    state,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic                  timeout_err
);

  localparam int unsigned CW1 = CNT_W + 1;

  seq_state_e r_state;
  seq_state_e w_state_nxt;

  logic [CNT_W-1:0] r_phase_cnt;
  logic [CNT_W-1:0] r_stable_cnt;
  logic [CNT_W-1:0] r_glitch_cnt;

  logic [CW1-1:0] w_phase_inc;
  logic [CW1-1:0] w_stable_inc;
  logic [CW1-1:0] w_glitch_inc;

  logic w_locked_s;
  logic w_phase_done_rst;
  logic w_phase_done_hold;
  logic w_timeout_hit;
  logic w_lock_ok;
  logic w_glitch_hit;
  logic w_lock_loss;
  logic w_timeout;
  logic w_in_lock_watch;

  logic                  r_pll_rst;
  logic                  r_sys_reset_n;
  logic                  r_ready;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;
  logic                  r_timeout_err;

  sys_clk_bit_sync #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  // A counter value n means n cycles already elapsed, so the current cycle is n+1.
  assign w_phase_inc  = {1'b0, r_phase_cnt} + CW1'(1);
  assign w_stable_inc = {1'b0, r_stable_cnt} + CW1'(1);
  assign w_glitch_inc = {1'b0, r_glitch_cnt} + CW1'(1);

  assign w_phase_done_rst  = w_phase_inc >= CW1'(PLL_RST_CYCLES);
  assign w_phase_done_hold = w_phase_inc >= CW1'(RELEASE_DELAY);
  assign w_timeout_hit     = w_phase_inc >= CW1'(LOCK_TIMEOUT_CYCLES);
  assign w_lock_ok         = w_locked_s && (w_stable_inc >= CW1'(LOCK_STABLE_CYCLES));
  assign w_glitch_hit      = !w_locked_s && (w_glitch_inc >= CW1'(LOCK_GLITCH_CYCLES));
  assign w_in_lock_watch   = (r_state == S_HOLD) || (r_state == S_RUN);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_PLL_RST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; lock beats timeout, lock loss beats release and software requests.
  always_comb begin
    w_state_nxt = r_state;
    w_lock_loss = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_PLL_RST: begin
        if (w_phase_done_rst) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_lock_ok) begin
          w_state_nxt = S_HOLD;
        end else if (w_timeout_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_PLL_RST;
        end
      end
      S_HOLD: begin
        if (w_glitch_hit) begin
          w_lock_loss = 1'b1;
          w_state_nxt = S_PLL_RST;
        end else if (w_phase_done_hold) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_glitch_hit) begin
          w_lock_loss = 1'b1;
          w_state_nxt = S_PLL_RST;
        end else if (sw_reset_req) begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_PLL_RST;
      end
    endcase
  end

  // Phase, lock-stable and lock-glitch counters; all restart on any state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase_cnt  <= '0;
      r_stable_cnt <= '0;
      r_glitch_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_phase_cnt  <= '0;
      r_stable_cnt <= '0;
      r_glitch_cnt <= '0;
    end else begin
      if (r_state != S_RUN) r_phase_cnt <= w_phase_inc[CNT_W-1:0];
      r_stable_cnt <= ((r_state == S_WAIT_LOCK) && w_locked_s) ? w_stable_inc[CNT_W-1:0] : '0;
      r_glitch_cnt <= (w_in_lock_watch && !w_locked_s) ? w_glitch_inc[CNT_W-1:0] : '0;
    end
  end

  // Outputs are flops decoded from the next state so they change with the state itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_loss_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_pll_rst     <= (w_state_nxt == S_PLL_RST);
      r_sys_reset_n <= (w_state_nxt == S_RUN);
      r_ready       <= (w_state_nxt == S_RUN);
      if (w_lock_loss && (r_loss_cnt != LOSS_CNT_MAX)) begin
        r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
      end
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_reset_n   = r_sys_reset_n;
  assign ready         = r_ready;
  assign state         = r_state;
  assign lock_loss_cnt = r_loss_cnt;
  assign timeout_err   = r_timeout_err;

endmodule
